// File: rtl/conv_output_stage.sv
// Output stage for the conv33 datapath: per-lane rounding shift, optional ReLU and
// saturation, followed by a first-word-fall-through FIFO with frame marking.
module conv_output_stage #(
  parameter int ACC_WIDTH = 20,
  parameter int OUT_WIDTH = 8,
  parameter int CH        = 4,
  parameter int DEPTH     = 16,
  parameter int SW        = $clog2(ACC_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CH*ACC_WIDTH-1:0]   in_data,
  input  logic                      cfg_relu,
  input  logic [SW-1:0]             cfg_shift,
  input  logic [15:0]               cfg_frame_len,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CH*OUT_WIDTH-1:0]   out_data,
  output logic                      out_last,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      sat_flag
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // Returns {clipped, quantised lane}; ReLU clamping is not reported as clipping.
  function automatic logic [OUT_WIDTH:0] quant(
    input logic signed [ACC_WIDTH-1:0] acc,
    input logic [SW-1:0]               sh,
    input logic                        relu
  );
    logic signed [ACC_WIDTH:0] v;
    logic signed [ACC_WIDTH:0] rnd;
    logic                      clip;
    logic [OUT_WIDTH-1:0]      q;
    v    = {acc[ACC_WIDTH-1], acc};
    rnd  = '0;
    clip = 1'b0;
    if (sh != '0) begin
      rnd = (ACC_WIDTH+1)'(1) <<< (sh - SW'(1));
      v   = (v + rnd) >>> sh;
    end else begin
      v = v;
    end
    if (relu && v[ACC_WIDTH]) begin
      v = '0;
    end else begin
      v = v;
    end
    if (v > SAT_MAX) begin
      q    = SAT_MAX[OUT_WIDTH-1:0];
      clip = 1'b1;
    end else if (v < SAT_MIN) begin
      q    = SAT_MIN[OUT_WIDTH-1:0];
      clip = 1'b1;
    end else begin
      q = v[OUT_WIDTH-1:0];
    end
    return {clip, q};
  endfunction

  logic                    s1_valid_r;
  logic [CH*OUT_WIDTH-1:0] s1_data_r;
  logic                    s1_sat_r;
  logic [CH*OUT_WIDTH-1:0] q_data_s;
  logic                    q_sat_s;
  logic [OUT_WIDTH:0]      lane_q_s;
  logic [AW-1:0]           wr_ptr_r;
  logic [AW-1:0]           rd_ptr_r;
  logic [CW-1:0]           count_r;
  logic [15:0]             frame_cnt_r;
  logic                    sat_r;
  logic                    accept_s;
  logic                    rd_en_s;
  logic [CH*OUT_WIDTH-1:0] mem_r [DEPTH];

  // Space check counts the beat in s1 so the FIFO can never overflow.
  assign in_ready   = ({1'b0, count_r} + {{CW{1'b0}}, s1_valid_r}) < (CW+1)'(DEPTH);
  assign accept_s   = in_valid && in_ready;
  assign out_valid  = (count_r != '0);
  assign rd_en_s    = out_valid && out_ready;
  assign out_data   = mem_r[rd_ptr_r];
  assign out_last   = out_valid && (cfg_frame_len != 16'd0) &&
                      (frame_cnt_r == (cfg_frame_len - 16'd1));
  assign fifo_count = count_r;
  assign sat_flag   = sat_r;

  // Quantise every lane of the incoming beat.
  always_comb begin
    q_data_s = '0;
    q_sat_s  = 1'b0;
    lane_q_s = '0;
    for (int k = 0; k < CH; k++) begin
      lane_q_s = quant(in_data[k*ACC_WIDTH +: ACC_WIDTH], cfg_shift, cfg_relu);
      q_data_s[k*OUT_WIDTH +: OUT_WIDTH] = lane_q_s[OUT_WIDTH-1:0];
      q_sat_s = q_sat_s | lane_q_s[OUT_WIDTH];
    end
  end

  // Quantise stage register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_sat_r   <= 1'b0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_data_r <= q_data_s;
        s1_sat_r  <= q_sat_s;
      end
    end
  end

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (s1_valid_r) begin
      mem_r[wr_ptr_r] <= s1_data_r;
    end
  end

  // Pointers, occupancy, frame position and sticky saturation.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      frame_cnt_r <= 16'd0;
      sat_r       <= 1'b0;
    end else begin
      if (s1_valid_r) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r    <= rd_ptr_r + AW'(1);
        frame_cnt_r <= out_last ? 16'd0 : (frame_cnt_r + 16'd1);
      end
      case ({s1_valid_r, rd_en_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      sat_r <= sat_r | (s1_valid_r & s1_sat_r);
    end
  end

endmodule

// File: tb/tb_conv_output_stage.sv
// Directed self-checking bench for conv_output_stage with default parameters.
module tb_conv_output_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [79:0] in_data;
  logic        cfg_relu;
  logic [4:0]  cfg_shift;
  logic [15:0] cfg_frame_len;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [4:0]  fifo_count;
  logic        sat_flag;

  int n_assert = 0;
  int n_fail   = 0;
  int acc_cnt;
  int popped;
  int rdy;

  conv_output_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_relu(cfg_relu), .cfg_shift(cfg_shift), .cfg_frame_len(cfg_frame_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .fifo_count(fifo_count), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [79:0] pk_in(input int a, input int b, input int c, input int d);
    return {20'(d), 20'(c), 20'(b), 20'(a)};
  endfunction

  function automatic logic [31:0] pk_out(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [79:0] bp_in(input int i);
    return pk_in(i, -i, 100 - i, 3 * i);
  endfunction

  function automatic logic [31:0] bp_out(input int i);
    return pk_out(i, -i, 100 - i, 3 * i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [79:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cfg_relu = 1'b0; cfg_shift = 5'd0; cfg_frame_len = 16'd0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_sat_flag", sat_flag, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // Passthrough with two-cycle latency
    send(pk_in(5, -3, 127, -128));
    chk("pass_lat_n1", out_valid, 0);
    tick();
    chk("pass_lat_n2", out_valid, 1);
    chk("pass_data", out_data, pk_out(5, -3, 127, -128));
    chk("pass_sat", sat_flag, 0);
    chk("pass_count", fifo_count, 1);
    pop();
    chk("pass_drained", out_valid, 0);
    chk("pass_count0", fifo_count, 0);

    // Rounding shift and saturation
    cfg_shift = 5'd2;
    send(pk_in(6, -6, 1000, -1000));
    chk("rnd_sat_early", sat_flag, 0);
    tick();
    chk("rnd_sat", sat_flag, 1);
    chk("rnd_data", out_data, pk_out(2, -1, 127, -128));
    pop();
    tick();
    chk("rnd_sat_sticky", sat_flag, 1);

    // ReLU: clamping to zero is not clipping, the 300 lane is
    do_reset();
    cfg_shift = 5'd0; cfg_relu = 1'b1;
    send(pk_in(-50, 50, 100, 0));
    tick();
    chk("relu_data_a", out_data, pk_out(0, 50, 100, 0));
    chk("relu_sat_a", sat_flag, 0);
    pop();
    send(pk_in(-50, 50, 300, 0));
    tick();
    chk("relu_data_b", out_data, pk_out(0, 50, 127, 0));
    chk("relu_sat_b", sat_flag, 1);
    pop();

    // Backpressure: exactly DEPTH beats accepted, then drained in order
    do_reset();
    cfg_relu = 1'b0;
    acc_cnt = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 24; c++) begin
      in_data = bp_in(acc_cnt);
      rdy = int'(in_ready);
      tick();
      if (rdy != 0) acc_cnt++;
    end
    in_valid = 1'b0;
    chk("bp_accepted", acc_cnt, 16);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_count", fifo_count, 16);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, bp_out(k));
      tick();
      if (k == 0) chk("bp_ready_rise", in_ready, 1);
    end
    out_ready = 1'b0;
    chk("bp_empty", fifo_count, 0);
    chk("bp_no_valid", out_valid, 0);

    // Frame marking with random stalls
    do_reset();
    cfg_frame_len = 16'd3;
    for (int i = 0; i < 7; i++) send(bp_in(20 + i));
    tick(); tick();
    chk("frm_count", fifo_count, 7);
    popped = 0;
    for (int c = 0; c < 200 && popped < 7; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      chk("frm_valid", out_valid, 1);
      chk("frm_data", out_data, bp_out(20 + popped));
      chk("frm_last", out_last, ((popped % 3) == 2) ? 1 : 0);
      tick();
      if (out_ready) popped++;
    end
    out_ready = 1'b0;
    chk("frm_popped", popped, 7);

    // Reset mid-frame with 5 beats buffered
    for (int i = 0; i < 5; i++) send(pk_in(1, 2, 300, 4));
    tick(); tick();
    chk("mid_count", fifo_count, 5);
    chk("mid_sat", sat_flag, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_sat", sat_flag, 0);
    chk("mid_rst_ready", in_ready, 1);
    rst = 1'b0;

    // New frame counts from zero; full throughput with out_ready high
    popped = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 3);
      in_data  = bp_in(c);
      if (c < 3) chk("thr_in_ready", in_ready, 1);
      if (out_valid) begin
        chk("new_data", out_data, bp_out(popped));
        chk("new_last", out_last, (popped == 2) ? 1 : 0);
        popped++;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("new_popped", popped, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
